// File: rtl/fibo_datapath.sv
// fibo_datapath: four-entry register file plus single-cycle ALU for the
// Fibonacci sequencer. Holds operands and iteration count, reports whether
// the last committed value was zero, and keeps a sticky ADD-carry flag.
module fibo_datapath #(
    parameter int unsigned SIZE       = 4,
    parameter int unsigned RESULT_REG = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [2:0]      alu_opcode,
    input  logic [1:0]      rd_addr1,
    input  logic [1:0]      rd_addr2,
    input  logic [1:0]      wrt_addr,
    input  logic            wrt_en,
    input  logic            load_data,
    input  logic [SIZE-1:0] DATA_IN,
    output logic            ZERO_FLAG,
    output logic [SIZE-1:0] RESULT,
    output logic            OVF
);

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_DEC  = 3'b011,
        OP_INC  = 3'b100,
        OP_CLR  = 3'b101,
        OP_MOV  = 3'b110,
        OP_NOP  = 3'b111
    } alu_op_e;

    localparam logic [1:0] RES_IDX = RESULT_REG[1:0];

    alu_op_e         op;
    logic [SIZE-1:0] opa;
    logic [SIZE-1:0] opb;
    logic [SIZE:0]   sum;
    logic [SIZE-1:0] alu_out;
    logic [SIZE-1:0] wr_data;
    logic            commit;

    logic [SIZE-1:0] regs_q [4];
    logic [SIZE-1:0] regs_d [4];
    logic            zero_flag_q, zero_flag_d;
    logic            ovf_q, ovf_d;

    assign op = alu_op_e'(alu_opcode);

    // Operand fetch and ALU; reads see the pre-write register contents.
    always_comb begin
        opa     = regs_q[rd_addr1];
        opb     = regs_q[rd_addr2];
        sum     = {1'b0, opa} + {1'b0, opb};
        alu_out = '0;
        case (op)
            OP_PASS: alu_out = opa;
            OP_ADD:  alu_out = sum[SIZE-1:0];
            OP_SUB:  alu_out = opa - opb;
            OP_DEC:  alu_out = opa - SIZE'(1);
            OP_INC:  alu_out = opa + SIZE'(1);
            OP_CLR:  alu_out = '0;
            OP_MOV:  alu_out = opb;
            OP_NOP:  alu_out = opa;
            default: alu_out = '0;
        endcase
    end

    // Write-back selection and next-state for registers and flags.
    always_comb begin
        wr_data     = load_data ? DATA_IN : alu_out;
        commit      = wrt_en & (load_data | (op != OP_NOP));
        regs_d      = regs_q;
        zero_flag_d = zero_flag_q;
        ovf_d       = ovf_q;
        if (commit) begin
            regs_d[wrt_addr] = wr_data;
            zero_flag_d      = (wr_data == '0);
            if (load_data)
                ovf_d = 1'b0;
            else if (op == OP_ADD && sum[SIZE])
                ovf_d = 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < 4; i++)
                regs_q[i] <= '0;
            zero_flag_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            zero_flag_q <= zero_flag_d;
            ovf_q       <= ovf_d;
        end
    end

    assign RESULT    = regs_q[RES_IDX];
    assign ZERO_FLAG = zero_flag_q;
    assign OVF       = ovf_q;

endmodule
